// File: rtl/ili_spi_scheduler.sv
// Arbitrates the ILI9225 SPI byte channel between register writes and pixel
// streaming, serialising each request into {dc, byte} words for spi_master.
module ili_spi_scheduler #(
  parameter logic [15:0] GRAM_INDEX = 16'h0022
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_req,
  input  logic [15:0] cmd_index,
  input  logic [15:0] cmd_data,
  output logic        cmd_ack,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  input  logic        pix_last,
  output logic        pix_ready,
  output logic [8:0]  spi_word,
  output logic        spi_valid,
  input  logic        spi_idle,
  output logic        busy,
  output logic        gram_open
);

  typedef enum logic [3:0] {
    IDLE, CMD_IH, CMD_IL, CMD_DH, CMD_DL, GR_IH, GR_IL, PIX_H, PIX_L
  } state_t;

  typedef enum logic [1:0] {ISSUE, WAIT_LO, WAIT_HI} phase_t;

  state_t      state, state_n;
  phase_t      phase, phase_n;
  logic [15:0] idx_q, idx_n, dat_q, dat_n, pix_q, pix_n;
  logic        last_q, last_n;
  logic        ack_n, ready_n, valid_n, gram_n;
  logic [8:0]  word_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= ISSUE;
      idx_q     <= '0;
      dat_q     <= '0;
      pix_q     <= '0;
      last_q    <= 1'b0;
      cmd_ack   <= 1'b0;
      pix_ready <= 1'b0;
      spi_valid <= 1'b0;
      spi_word  <= '0;
      gram_open <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      idx_q     <= idx_n;
      dat_q     <= dat_n;
      pix_q     <= pix_n;
      last_q    <= last_n;
      cmd_ack   <= ack_n;
      pix_ready <= ready_n;
      spi_valid <= valid_n;
      spi_word  <= word_n;
      gram_open <= gram_n;
    end
  end

  // Every pixel returns to IDLE, so a pending command is only ever taken
  // between pixels.
  always_comb begin
    state_n = state;
    phase_n = phase;
    if (state == IDLE) begin
      phase_n = ISSUE;
      if (cmd_req)                      state_n = CMD_IH;
      else if (pix_valid && !gram_open) state_n = GR_IH;
      else if (pix_valid)               state_n = PIX_H;
    end else begin
      case (phase)
        ISSUE:   if (spi_idle)  phase_n = WAIT_LO;
        WAIT_LO: if (!spi_idle) phase_n = WAIT_HI;
        WAIT_HI: if (spi_idle) begin
          phase_n = ISSUE;
          case (state)
            CMD_IH:  state_n = CMD_IL;
            CMD_IL:  state_n = CMD_DH;
            CMD_DH:  state_n = CMD_DL;
            GR_IH:   state_n = GR_IL;
            PIX_H:   state_n = PIX_L;
            default: state_n = IDLE;
          endcase
        end
        default: phase_n = ISSUE;
      endcase
    end
  end

  always_comb begin
    idx_n   = idx_q;
    dat_n   = dat_q;
    pix_n   = pix_q;
    last_n  = last_q;
    ack_n   = 1'b0;
    ready_n = 1'b0;
    valid_n = 1'b0;
    gram_n  = gram_open;
    if (state == IDLE) begin
      if (cmd_req) begin
        idx_n  = cmd_index;
        dat_n  = cmd_data;
        ack_n  = 1'b1;
        gram_n = 1'b0;
      end else if (pix_valid && gram_open) begin
        pix_n   = pix_data;
        last_n  = pix_last;
        ready_n = 1'b1;
      end
    end else begin
      if (phase == ISSUE && spi_idle) valid_n = 1'b1;
      if (phase == WAIT_HI && spi_idle) begin
        if (state == GR_IL)           gram_n = 1'b1;
        if (state == PIX_L && last_q) gram_n = 1'b0;
      end
    end
    // Word is loaded on entry to each byte state and held until it is left.
    case (state_n)
      CMD_IH:  word_n = {1'b0, idx_n[15:8]};
      CMD_IL:  word_n = {1'b0, idx_n[7:0]};
      CMD_DH:  word_n = {1'b1, dat_n[15:8]};
      CMD_DL:  word_n = {1'b1, dat_n[7:0]};
      GR_IH:   word_n = {1'b0, GRAM_INDEX[15:8]};
      GR_IL:   word_n = {1'b0, GRAM_INDEX[7:0]};
      PIX_H:   word_n = {1'b1, pix_n[15:8]};
      PIX_L:   word_n = {1'b1, pix_n[7:0]};
      default: word_n = '0;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ili_spi_scheduler.sv
// Bench for ili_spi_scheduler: behavioural spi_master responder plus a queue of
// expected {dc, byte} words checked on every spi_valid strobe.
module tb_ili_spi_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_req;
  logic [15:0] cmd_index, cmd_data;
  logic        cmd_ack;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_last;
  logic        pix_ready;
  logic [8:0]  spi_word;
  logic        spi_valid;
  logic        spi_idle;
  logic        busy;
  logic        gram_open;

  ili_spi_scheduler #(.GRAM_INDEX(16'h0022)) dut (
    .clk(clk), .rst(rst),
    .cmd_req(cmd_req), .cmd_index(cmd_index), .cmd_data(cmd_data), .cmd_ack(cmd_ack),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last), .pix_ready(pix_ready),
    .spi_word(spi_word), .spi_valid(spi_valid), .spi_idle(spi_idle),
    .busy(busy), .gram_open(gram_open)
  );

  always #5 clk = ~clk;

  logic [8:0] exp_q[$];
  logic [8:0] cur_word;
  int vec = 0, mis = 0;
  int n_valid = 0, n_ack = 0, n_ready = 0;
  int busy_cnt = 0;

  // One clock of simulation: spi_master model (idle low 8 cycles per byte)
  // and scoreboard pop on each issue strobe.
  task automatic step();
    logic [8:0] e;
    @(posedge clk); #1;
    vec++;
    if (cmd_ack && pix_ready) begin
      mis++; $display("FAIL ack_ready_overlap: cmd_ack=%b pix_ready=%b required not both 1", cmd_ack, pix_ready);
    end
    if (cmd_ack)   n_ack++;
    if (pix_ready) n_ready++;
    if (spi_valid) begin
      n_valid++;
      vec++;
      if (exp_q.size() == 0) begin
        mis++; $display("FAIL spi_word_unexpected: got %03h with no word expected", spi_word);
      end else begin
        e = exp_q.pop_front();
        if (spi_word !== e) begin
          mis++; $display("FAIL spi_word: got %03h expected %03h", spi_word, e);
        end
      end
      cur_word = spi_word;
      busy_cnt = 8;
      spi_idle = 1'b0;
    end else if (busy_cnt > 0) begin
      vec++;
      if (spi_word !== cur_word) begin
        mis++; $display("FAIL word_stable: got %03h expected %03h", spi_word, cur_word);
      end
      busy_cnt--;
      if (busy_cnt == 0) spi_idle = 1'b1;
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || busy || busy_cnt != 0) && k < 3000) begin
      step(); k++;
    end
    vec++;
    if (k >= 3000) begin
      mis++; $display("FAIL drain_timeout: queue=%0d busy=%b required queue=0 busy=0", exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic wait_ready(input string what);
    int k = 0;
    do begin step(); k++; end while (!pix_ready && k < 3000);
    vec++;
    if (!pix_ready) begin
      mis++; $display("FAIL %s: pix_ready=0 required 1 within 3000 cycles", what);
    end
  endtask

  task automatic wait_ack(input string what);
    int k = 0;
    do begin step(); k++; end while (!cmd_ack && k < 3000);
    vec++;
    if (!cmd_ack) begin
      mis++; $display("FAIL %s: cmd_ack=0 required 1 within 3000 cycles", what);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    vec++; if (cmd_ack !== 1'b0)   begin mis++; $display("FAIL reset_cmd_ack: got %b expected 0", cmd_ack); end
    vec++; if (pix_ready !== 1'b0) begin mis++; $display("FAIL reset_pix_ready: got %b expected 0", pix_ready); end
    vec++; if (spi_valid !== 1'b0) begin mis++; $display("FAIL reset_spi_valid: got %b expected 0", spi_valid); end
    vec++; if (spi_word !== 9'h000) begin mis++; $display("FAIL reset_spi_word: got %03h expected 000", spi_word); end
    vec++; if (busy !== 1'b0)      begin mis++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vec++; if (gram_open !== 1'b0) begin mis++; $display("FAIL reset_gram_open: got %b expected 0", gram_open); end
  endtask

  task automatic test_cmd();
    int a0 = n_ack;
    exp_q.push_back(9'h000); exp_q.push_back(9'h010);
    exp_q.push_back(9'h108); exp_q.push_back(9'h100);
    cmd_index = 16'h0010; cmd_data = 16'h0800; cmd_req = 1'b1;
    step();
    vec++; if (cmd_ack !== 1'b1) begin mis++; $display("FAIL cmd_ack_latency: got %b expected 1", cmd_ack); end
    vec++; if (busy !== 1'b1)    begin mis++; $display("FAIL cmd_busy: got %b expected 1", busy); end
    cmd_req = 1'b0;
    step();
    vec++; if (spi_valid !== 1'b1) begin mis++; $display("FAIL cmd_first_issue: got %b expected 1", spi_valid); end
    drain();
    vec++; if (n_ack - a0 != 1) begin mis++; $display("FAIL cmd_ack_count: got %0d expected 1", n_ack - a0); end
    vec++; if (busy !== 1'b0)   begin mis++; $display("FAIL cmd_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_pixel();
    int r0 = n_ready;
    exp_q.push_back(9'h000); exp_q.push_back(9'h022);
    exp_q.push_back(9'h1F8); exp_q.push_back(9'h100);
    pix_data = 16'hF800; pix_last = 1'b1; pix_valid = 1'b1;
    wait_ready("pixel_ready");
    vec++; if (gram_open !== 1'b1) begin mis++; $display("FAIL pixel_gram_open: got %b expected 1", gram_open); end
    pix_valid = 1'b0;
    drain();
    vec++; if (gram_open !== 1'b0)  begin mis++; $display("FAIL pixel_gram_close: got %b expected 0", gram_open); end
    vec++; if (n_ready - r0 != 1)   begin mis++; $display("FAIL pixel_ready_count: got %0d expected 1", n_ready - r0); end
  endtask

  task automatic test_burst();
    logic [15:0] px[3] = '{16'h1234, 16'hABCD, 16'h0001};
    int r0 = n_ready;
    exp_q.push_back(9'h000); exp_q.push_back(9'h022);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b1, px[i][15:8]});
      exp_q.push_back({1'b1, px[i][7:0]});
    end
    for (int i = 0; i < 3; i++) begin
      pix_data = px[i]; pix_last = (i == 2); pix_valid = 1'b1;
      wait_ready("burst_ready");
    end
    pix_valid = 1'b0;
    drain();
    vec++; if (gram_open !== 1'b0) begin mis++; $display("FAIL burst_gram_close: got %b expected 0", gram_open); end
    vec++; if (n_ready - r0 != 3)  begin mis++; $display("FAIL burst_ready_count: got %0d expected 3", n_ready - r0); end
  endtask

  task automatic test_preempt();
    int r0, v0, k;
    logic [8:0] w[14] = '{9'h000, 9'h022, 9'h111, 9'h111,
                          9'h000, 9'h036, 9'h100, 9'h1AF,
                          9'h000, 9'h022, 9'h122, 9'h122, 9'h133, 9'h133};
    foreach (w[i]) exp_q.push_back(w[i]);
    r0 = n_ready;
    pix_data = 16'h1111; pix_last = 1'b0; pix_valid = 1'b1;
    wait_ready("preempt_p1_ready");
    pix_data = 16'h2222;
    v0 = n_valid; k = 0;
    while (n_valid < v0 + 2 && k < 3000) begin step(); k++; end
    vec++; if (n_valid < v0 + 2) begin mis++; $display("FAIL preempt_pix_l: strobes=%0d expected %0d", n_valid - v0, 2); end
    cmd_index = 16'h0036; cmd_data = 16'h00AF; cmd_req = 1'b1;
    wait_ack("preempt_ack");
    vec++; if (n_ready - r0 != 1) begin mis++; $display("FAIL preempt_order: ready count %0d expected 1", n_ready - r0); end
    cmd_req = 1'b0;
    wait_ready("preempt_p2_ready");
    pix_data = 16'h3333; pix_last = 1'b1;
    wait_ready("preempt_p3_ready");
    pix_valid = 1'b0;
    drain();
    vec++; if (gram_open !== 1'b0) begin mis++; $display("FAIL preempt_gram_close: got %b expected 0", gram_open); end
  endtask

  task automatic test_stall();
    exp_q.push_back(9'h012); exp_q.push_back(9'h034);
    exp_q.push_back(9'h156); exp_q.push_back(9'h178);
    spi_idle = 1'b0;
    cmd_index = 16'h1234; cmd_data = 16'h5678; cmd_req = 1'b1;
    step();
    vec++; if (cmd_ack !== 1'b1) begin mis++; $display("FAIL stall_ack: got %b expected 1", cmd_ack); end
    cmd_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      vec++; if (spi_valid !== 1'b0)  begin mis++; $display("FAIL stall_valid: got %b expected 0", spi_valid); end
      vec++; if (spi_word !== 9'h012) begin mis++; $display("FAIL stall_word: got %03h expected 012", spi_word); end
    end
    spi_idle = 1'b1;
    drain();
  endtask

  task automatic test_reset_mid();
    int v0, k;
    exp_q.push_back(9'h000); exp_q.push_back(9'h0AA); exp_q.push_back(9'h155);
    cmd_index = 16'h00AA; cmd_data = 16'h5555; cmd_req = 1'b1;
    wait_ack("rmid_ack");
    cmd_req = 1'b0;
    v0 = n_valid - 0; k = 0;
    while (n_valid < v0 + 3 && k < 3000) begin step(); k++; end
    vec++; if (n_valid < v0 + 3) begin mis++; $display("FAIL rmid_reach_dh: strobes=%0d expected 3", n_valid - v0); end
    busy_cnt = 0; spi_idle = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0;
    vec++; if (cmd_ack !== 1'b0)    begin mis++; $display("FAIL rmid_cmd_ack: got %b expected 0", cmd_ack); end
    vec++; if (pix_ready !== 1'b0)  begin mis++; $display("FAIL rmid_pix_ready: got %b expected 0", pix_ready); end
    vec++; if (spi_valid !== 1'b0)  begin mis++; $display("FAIL rmid_spi_valid: got %b expected 0", spi_valid); end
    vec++; if (spi_word !== 9'h000) begin mis++; $display("FAIL rmid_spi_word: got %03h expected 000", spi_word); end
    vec++; if (busy !== 1'b0)       begin mis++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    vec++; if (gram_open !== 1'b0)  begin mis++; $display("FAIL rmid_gram_open: got %b expected 0", gram_open); end
    exp_q.push_back(9'h000); exp_q.push_back(9'h010);
    exp_q.push_back(9'h108); exp_q.push_back(9'h100);
    cmd_index = 16'h0010; cmd_data = 16'h0800; cmd_req = 1'b1;
    wait_ack("rmid_fresh_ack");
    cmd_req = 1'b0;
    drain();
  endtask

  task automatic test_simultaneous();
    exp_q.push_back(9'h000); exp_q.push_back(9'h012);
    exp_q.push_back(9'h134); exp_q.push_back(9'h156);
    exp_q.push_back(9'h000); exp_q.push_back(9'h022);
    exp_q.push_back(9'h1BE); exp_q.push_back(9'h1EF);
    cmd_index = 16'h0012; cmd_data = 16'h3456; cmd_req = 1'b1;
    pix_data = 16'hBEEF; pix_last = 1'b1; pix_valid = 1'b1;
    step();
    vec++; if (cmd_ack !== 1'b1)   begin mis++; $display("FAIL simul_ack: got %b expected 1", cmd_ack); end
    vec++; if (pix_ready !== 1'b0) begin mis++; $display("FAIL simul_ready: got %b expected 0", pix_ready); end
    cmd_req = 1'b0;
    wait_ready("simul_pix_ready");
    pix_valid = 1'b0;
    drain();
  endtask

  initial begin
    rst = 1'b1; cmd_req = 1'b0; cmd_index = '0; cmd_data = '0;
    pix_valid = 1'b0; pix_data = '0; pix_last = 1'b0; spi_idle = 1'b1;
    test_reset();
    test_cmd();
    test_pixel();
    test_burst();
    test_preempt();
    test_stall();
    test_reset_mid();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
